// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: PC select encoding,
// controller states and register-index width.
package hazard_ctrl_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    PCSEL_NPC    = 2'd0,
    PCSEL_BRANCH = 2'd1,
    PCSEL_JUMP   = 2'd2,
    PCSEL_JR     = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LU_STALL   = 2'd1,
    HALT_DRAIN = 2'd2,
    HALTED     = 2'd3
  } hz_state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones instead of wrapping; i_clear is synchronous.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-register enable/flush, PC select and
// enable, halt drain and stall/flush perf counters.
//   state      | meaning
//   RUN        | normal issue; hazards detected here
//   LU_STALL   | extra load-use bubbles, lu_cnt remaining
//   HALT_DRAIN | bubbles fed at IF_ID until the pipe is empty
//   HALTED     | frozen, halted=1 until reset
module pipeline_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE   = 4,
  parameter int BR_STAGE = 2,
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic              br_taken,
  input  pc_sel_t           jump_IF_ID,
  input  logic              halt_IF_ID,
  input  logic              dREN_ID_EX,
  input  logic [REG_W-1:0]  Rt_ID_EX,
  input  logic [REG_W-1:0]  Rs_IF_ID,
  input  logic [REG_W-1:0]  Rt_IF_ID,
  input  logic              uses_rt_IF_ID,
  output logic [NSTAGE-1:0] enable,
  output logic [NSTAGE-1:0] flush,
  output logic              enable_pc,
  output pc_sel_t           PCSrc,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic [NSTAGE-1:0] BR_MASK = NSTAGE'((1 << (BR_STAGE + 1)) - 1);

  hz_state_t  r_state, w_next_state;
  logic [1:0] r_lu_cnt, w_lu_next;
  logic [2:0] r_dr_cnt, w_dr_next;
  logic       w_dwait, w_load_use, w_stall_inc, w_flush_inc;

  assign w_dwait    = (dmemREN | dmemWEN) & ~dhit;
  assign w_load_use = dREN_ID_EX && (Rt_ID_EX != '0) &&
                      ((Rt_ID_EX == Rs_IF_ID) || (uses_rt_IF_ID && (Rt_ID_EX == Rt_IF_ID)));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= RUN;
      r_lu_cnt <= '0;
      r_dr_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_lu_cnt <= w_lu_next;
      r_dr_cnt <= w_dr_next;
    end
  end

  always_comb begin
    enable       = '1;
    flush        = '0;
    enable_pc    = 1'b1;
    PCSrc        = PCSEL_NPC;
    halted       = 1'b0;
    w_next_state = r_state;
    w_lu_next    = r_lu_cnt;
    w_dr_next    = r_dr_cnt;
    w_flush_inc  = 1'b0;
    if (!nRST) begin
      enable    = '0;
      flush     = '1;
      enable_pc = 1'b0;
    end else if (r_state == HALTED) begin
      enable    = '0;
      enable_pc = 1'b0;
      halted    = 1'b1;
    end else if (w_dwait) begin
      enable    = '0;
      enable_pc = 1'b0;
    end else if (br_taken) begin
      // A branch waiting on fetch freezes everything so the redirect is not lost.
      if (ihit) begin
        PCSrc        = PCSEL_BRANCH;
        flush        = BR_MASK;
        w_flush_inc  = 1'b1;
        w_next_state = RUN;
      end else begin
        enable    = '0;
        enable_pc = 1'b0;
      end
    end else if (r_state == hazard_ctrl_pkg::LU_STALL) begin
      enable[0] = 1'b0;
      flush[1]  = 1'b1;
      enable_pc = 1'b0;
      if (r_lu_cnt <= 2'd1) begin
        w_next_state = RUN;
        w_lu_next    = '0;
      end else begin
        w_lu_next = r_lu_cnt - 2'd1;
      end
    end else if (r_state == HALT_DRAIN) begin
      enable_pc = 1'b0;
      flush[0]  = 1'b1;
      if (r_dr_cnt <= 3'd1) begin
        w_next_state = HALTED;
        w_dr_next    = '0;
      end else begin
        w_dr_next = r_dr_cnt - 3'd1;
      end
    end else if (w_load_use) begin
      enable[0] = 1'b0;
      flush[1]  = 1'b1;
      enable_pc = 1'b0;
      if (LU_STALL > 1) begin
        w_next_state = hazard_ctrl_pkg::LU_STALL;
        w_lu_next    = 2'(LU_STALL - 1);
      end
    end else if (halt_IF_ID) begin
      enable_pc    = 1'b0;
      flush[0]     = 1'b1;
      w_next_state = HALT_DRAIN;
      w_dr_next    = 3'(NSTAGE - 1);
    end else if ((jump_IF_ID != PCSEL_NPC) && ihit) begin
      PCSrc       = jump_IF_ID;
      flush[0]    = 1'b1;
      w_flush_inc = 1'b1;
    end else if (!ihit) begin
      enable_pc = 1'b0;
      enable[0] = 1'b0;
      flush[1]  = 1'b1;
    end
  end

  assign w_stall_inc = nRST && !enable_pc &&
                       ((r_state == RUN) || (r_state == hazard_ctrl_pkg::LU_STALL));

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk  (CLK),
    .i_clear(!nRST),
    .i_inc  (w_stall_inc),
    .o_cnt  (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk  (CLK),
    .i_clear(!nRST),
    .i_inc  (w_flush_inc),
    .o_cnt  (flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (NSTAGE=4, BR_STAGE=2, LU_STALL=2,
// CNT_W=5) with hand-computed expected outputs and counter values.
module tb_pipeline_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST, ihit, dhit, dmemREN, dmemWEN, br_taken, halt_IF_ID;
  logic       dREN_ID_EX, uses_rt_IF_ID;
  pc_sel_t    jump_IF_ID, PCSrc;
  logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
  logic [3:0] enable, flush;
  logic       enable_pc, halted;
  logic [4:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.NSTAGE(4), .BR_STAGE(2), .LU_STALL(2), .CNT_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .br_taken(br_taken), .jump_IF_ID(jump_IF_ID),
    .halt_IF_ID(halt_IF_ID), .dREN_ID_EX(dREN_ID_EX), .Rt_ID_EX(Rt_ID_EX),
    .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .uses_rt_IF_ID(uses_rt_IF_ID),
    .enable(enable), .flush(flush), .enable_pc(enable_pc), .PCSrc(PCSrc),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {enable, flush, enable_pc, PCSrc, halted}
  function automatic logic [11:0] ex(input logic [3:0] en, input logic [3:0] fl,
                                     input logic epc, input logic [1:0] pc, input logic h);
    return {en, fl, epc, pc, h};
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
    end
  endtask

  task automatic chk_o(input string tag, input logic [11:0] exp);
    #1;
    chk(tag, {enable, flush, enable_pc, PCSrc, halted}, exp);
  endtask

  task automatic chk_c(input string tag, input logic [4:0] st, input logic [4:0] fl);
    chk({tag, "_stall"}, {7'd0, stall_cnt}, {7'd0, st});
    chk({tag, "_flush"}, {7'd0, flush_cnt}, {7'd0, fl});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; br_taken = 1'b0;
    jump_IF_ID = PCSEL_NPC; halt_IF_ID = 1'b0; dREN_ID_EX = 1'b0;
    Rt_ID_EX = '0; Rs_IF_ID = '0; Rt_IF_ID = '0; uses_rt_IF_ID = 1'b0;
  endtask

  localparam logic [11:0] RUN_O  = 12'b1111_0000_1_00_0;
  localparam logic [11:0] LU_O   = 12'b1110_0010_0_00_0;
  localparam logic [11:0] FRZ_O  = 12'b0000_0000_0_00_0;
  localparam logic [11:0] BR_O   = 12'b1111_0111_1_01_0;
  localparam logic [11:0] HLT_O  = 12'b1111_0001_0_00_0;
  localparam logic [11:0] DONE_O = 12'b0000_0000_0_00_1;
  localparam logic [11:0] RST_O  = 12'b0000_1111_0_00_0;

  initial begin
    idle();
    nRST = 1'b0;
    #2;
    chk_o("reset_out", RST_O);
    tick();
    chk_c("reset_cnt", 5'd0, 5'd0);
    nRST = 1'b1;
    chk_o("run_idle", RUN_O);
    tick();

    // load-use, two bubbles, hazard held during LU_STALL
    dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5;
    chk_o("lu_first", LU_O);
    tick();
    chk_o("lu_second", LU_O);
    tick();
    idle();
    chk_o("lu_back_run", RUN_O);
    chk_c("lu", 5'd2, 5'd0);
    tick();

    dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0;
    chk_o("lu_r0", RUN_O);
    tick();
    Rt_ID_EX = 5'd7; Rt_IF_ID = 5'd7; Rs_IF_ID = 5'd3; uses_rt_IF_ID = 1'b0;
    chk_o("lu_rt_unused", RUN_O);
    tick();
    uses_rt_IF_ID = 1'b1;
    chk_o("lu_rt_used", LU_O);
    tick();
    idle();
    chk_o("lu_rt_second", LU_O);
    tick();

    // branch with and without fetch hit
    br_taken = 1'b1;
    chk_o("br_hit", BR_O);
    tick();
    chk_c("br_hit", 5'd4, 5'd1);
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_o("br_miss_frozen", FRZ_O);
      tick();
    end
    ihit = 1'b1;
    chk_o("br_redirect", BR_O);
    tick();
    chk_c("br_miss", 5'd7, 5'd2);

    // data wait freezes LU_STALL countdown
    idle();
    dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd9; Rs_IF_ID = 5'd9;
    chk_o("lu_dw_enter", LU_O);
    tick();
    idle();
    dmemREN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_o("lu_dwait", FRZ_O);
      tick();
    end
    dmemREN = 1'b0;
    chk_o("lu_resume", LU_O);
    tick();
    chk_o("lu_dw_exit", RUN_O);
    chk_c("lu_dw", 5'd13, 5'd2);
    dmemWEN = 1'b1; dhit = 1'b1;
    chk_o("dwen_hit", RUN_O);
    tick();
    idle();

    // jump / jr
    jump_IF_ID = PCSEL_JR;
    chk_o("jr_hit", 12'b1111_0001_1_11_0);
    tick();
    ihit = 1'b0;
    chk_o("jump_nohit", LU_O);
    tick();
    chk_c("jump", 5'd14, 5'd3);
    idle();

    // halt drain then sticky halted
    halt_IF_ID = 1'b1;
    chk_o("halt_detect", HLT_O);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk_o("halt_drain", HLT_O);
      tick();
    end
    chk_o("halted", DONE_O);
    br_taken = 1'b1;
    tick();
    chk_o("halted_sticky", DONE_O);
    chk_c("halted", 5'd15, 5'd3);

    nRST = 1'b0;
    chk_o("rst_from_halted", RST_O);
    tick();
    nRST = 1'b1;
    idle();
    chk_o("run_after_rst", RUN_O);

    // branch aborts drain
    halt_IF_ID = 1'b1;
    tick();
    idle();
    chk_o("drain_pre_abort", HLT_O);
    tick();
    br_taken = 1'b1;
    chk_o("drain_abort_br", BR_O);
    tick();
    idle();
    chk_o("abort_run", RUN_O);
    chk_c("abort", 5'd1, 5'd1);

    // reset in the middle of a drain
    halt_IF_ID = 1'b1;
    tick();
    idle();
    tick();
    nRST = 1'b0;
    chk_o("rst_mid_drain", RST_O);
    tick();
    nRST = 1'b1;
    chk_o("rst_drain_run", RUN_O);
    chk_c("rst_drain", 5'd0, 5'd0);

    // saturation and dwait over branch
    ihit = 1'b0;
    for (int i = 0; i < 35; i++) tick();
    chk_c("sat", 5'd31, 5'd0);
    ihit = 1'b1; dmemREN = 1'b1; br_taken = 1'b1;
    chk_o("dwait_over_br", FRZ_O);
    tick();
    chk_c("dwait_br", 5'd31, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
